// File: rtl/hci_package.sv
// Shared HCI definitions: protocol widths, the response entry stored by memory
// targets, and a byte-enable merge helper.
package hci_package;

   localparam int unsigned HCI_DW = 32;
   localparam int unsigned HCI_BW = HCI_DW / 8;
   localparam int unsigned HCI_IW = 8;

   // One queued response: read data (zero for write responses) and the request id
   typedef struct packed {
      logic [HCI_DW-1:0] r_data;
      logic [HCI_IW-1:0] r_id;
   } hci_rsp_entry_t;

   // Replace each byte of old_word whose enable bit is set with the new byte
   function automatic logic [HCI_DW-1:0] be_merge(input logic [HCI_DW-1:0] old_word,
                                                  input logic [HCI_DW-1:0] new_word,
                                                  input logic [HCI_BW-1:0] be);
      logic [HCI_DW-1:0] res;
      res = old_word;
      for (int k = 0; k < int'(HCI_BW); k++) begin
         if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/hci_core_intf.sv
// HCI core protocol bundle.
//   request : req/gnt handshake, add, wen (1 = read), data, be, id, user, ecc, ereq/egnt
//   response: r_valid/r_ready handshake, r_data, r_id, r_user, r_opc, r_ecc, r_evalid
interface hci_core_intf #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned IW = hci_package::HCI_IW,
   parameter int unsigned UW = 1,
   parameter int unsigned EW = 1
) ();

   logic            req;
   logic            gnt;
   logic [AW-1:0]   add;
   logic            wen;
   logic [DW-1:0]   data;
   logic [DW/8-1:0] be;
   logic [UW-1:0]   user;
   logic [IW-1:0]   id;
   logic [EW-1:0]   ecc;
   logic            ereq;
   logic            egnt;

   logic            r_valid;
   logic            r_ready;
   logic [DW-1:0]   r_data;
   logic [UW-1:0]   r_user;
   logic [IW-1:0]   r_id;
   logic            r_opc;
   logic [EW-1:0]   r_ecc;
   logic            r_evalid;

   modport initiator (
      output req, add, wen, data, be, user, id, ecc, ereq, r_ready,
      input  gnt, egnt, r_valid, r_data, r_user, r_id, r_opc, r_ecc, r_evalid
   );

   modport target (
      input  req, add, wen, data, be, user, id, ecc, ereq, r_ready,
      output gnt, egnt, r_valid, r_data, r_user, r_id, r_opc, r_ecc, r_evalid
   );

endinterface

// File: rtl/hci_core_mem_target_rsp_fifo.sv
// Response FIFO for the memory target.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous flush (wins over push/pop in the same cycle)
//   push_i/push_data_i, pop_i/pop_data_o : enqueue / dequeue head
//   full_o, empty_o, count_o : occupancy
module hci_core_mem_target_rsp_fifo
   import hci_package::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  hci_rsp_entry_t   push_data_i,
   input  logic             pop_i,
   output hci_rsp_entry_t   pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   hci_rsp_entry_t   store_q [DEPTH];
   hci_rsp_entry_t   store_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap modulo DEPTH, which need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = store_q[rd_ptr_q];

   // Next-state: guarded push/pop, clear resets occupancy but leaves storage
   always_comb begin
      store_d  = store_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            store_d[wr_ptr_q] = push_data_i;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) store_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         store_q  <= store_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/hci_core_mem_target.sv
// Single-port word memory acting as an HCI core target.
//   clk_i, rst_ni : clock, async active-low reset (also zeroes the memory)
//   clear_i       : synchronous flush of pending responses; memory untouched
//   tcdm          : HCI core target port; reads answer after one cycle through
//                   a response FIFO, grant is withheld only while that FIFO is full
module hci_core_mem_target
   import hci_package::*;
#(
   parameter int unsigned NB_WORDS       = 256,
   parameter int unsigned RSP_FIFO_DEPTH = 2,
   parameter int unsigned WRITE_RESP     = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   hci_core_intf.target tcdm
);

   localparam int unsigned IDX_W = $clog2(NB_WORDS);
   localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

   logic [HCI_DW-1:0] mem_q [NB_WORDS];
   logic [HCI_DW-1:0] mem_word_d;
   logic [IDX_W-1:0]  idx;
   logic [HCI_DW-1:0] rd_word;
   logic              handshake;
   logic              mem_we;
   logic              push;
   hci_rsp_entry_t    push_data;
   hci_rsp_entry_t    head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              unused_sig;

   // Request decode; grant depends only on FIFO occupancy
   always_comb begin
      idx              = tcdm.add[IDX_W+1:2];
      rd_word          = mem_q[idx];
      handshake        = tcdm.req & ~fifo_full;
      mem_we           = handshake & ~tcdm.wen;
      mem_word_d       = be_merge(rd_word, tcdm.data, tcdm.be);
      push             = handshake & (tcdm.wen | (WRITE_RESP != 0));
      push_data.r_data = tcdm.wen ? rd_word : '0;
      push_data.r_id   = tcdm.id;
   end

   // Memory array with byte-enable writes; reads see pre-edge contents
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NB_WORDS); i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[idx] <= mem_word_d;
      end
   end

   hci_core_mem_target_rsp_fifo #(
      .DEPTH (RSP_FIFO_DEPTH)
   ) i_rsp_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (tcdm.r_ready),
      .pop_data_o  (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign tcdm.gnt      = ~fifo_full;
   assign tcdm.r_valid  = ~fifo_empty;
   assign tcdm.r_data   = head.r_data;
   assign tcdm.r_id     = head.r_id;
   assign tcdm.r_user   = '0;
   assign tcdm.r_opc    = 1'b0;
   assign tcdm.r_ecc    = '0;
   assign tcdm.egnt     = 1'b1;
   assign tcdm.r_evalid = 1'b0;

   // Inputs the target deliberately ignores
   assign unused_sig = ^{tcdm.user, tcdm.ecc, tcdm.ereq, tcdm.add[1:0],
                         tcdm.add[31:IDX_W+2], fifo_count};

endmodule

// File: tb/tb_hci_core_mem_target.sv
// Directed bench: dut_a (WRITE_RESP=1) and dut_b (WRITE_RESP=0), depth 2, 256 words.
module tb_hci_core_mem_target;
   import hci_package::*;

   typedef struct {
      logic        wen;
      logic [31:0] add;
      logic [31:0] data;
      logic [3:0]  be;
      logic [7:0]  id;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic clear_a;
   logic clear_b;
   int   checks = 0;
   int   errors = 0;
   vec_t vec_a [12];
   vec_t vec_b [5];

   always #5 clk = ~clk;

   hci_core_intf tcdm_a ();
   hci_core_intf tcdm_b ();

   hci_core_mem_target #(.NB_WORDS(256), .RSP_FIFO_DEPTH(2), .WRITE_RESP(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_a), .tcdm(tcdm_a));

   hci_core_mem_target #(.NB_WORDS(256), .RSP_FIFO_DEPTH(2), .WRITE_RESP(0)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_b), .tcdm(tcdm_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic req, input logic wen, input logic [31:0] add,
                          input logic [31:0] data, input logic [3:0] be, input logic [7:0] id);
      tcdm_a.req = req; tcdm_a.wen = wen; tcdm_a.add = add;
      tcdm_a.data = data; tcdm_a.be = be; tcdm_a.id = id;
   endtask

   task automatic drive_b(input logic req, input logic wen, input logic [31:0] add,
                          input logic [31:0] data, input logic [3:0] be, input logic [7:0] id);
      tcdm_b.req = req; tcdm_b.wen = wen; tcdm_b.add = add;
      tcdm_b.data = data; tcdm_b.be = be; tcdm_b.id = id;
   endtask

   initial begin
      // wen, add, data, be, id, exp_valid, exp_data (r_ready held at 1)
      vec_a[0]  = '{1'b0, 32'h010, 32'hDEADBEEF, 4'hF, 8'd1,  1'b1, 32'h0};
      vec_a[1]  = '{1'b1, 32'h010, 32'h0,        4'h0, 8'd2,  1'b1, 32'hDEADBEEF};
      vec_a[2]  = '{1'b0, 32'h020, 32'h11223344, 4'hF, 8'd3,  1'b1, 32'h0};
      vec_a[3]  = '{1'b0, 32'h020, 32'hAABBCCDD, 4'h5, 8'd4,  1'b1, 32'h0};
      vec_a[4]  = '{1'b1, 32'h020, 32'h0,        4'h0, 8'd5,  1'b1, 32'h11BB33DD};
      vec_a[5]  = '{1'b1, 32'h013, 32'h0,        4'h0, 8'd6,  1'b1, 32'hDEADBEEF};
      vec_a[6]  = '{1'b1, 32'h410, 32'h0,        4'h0, 8'd7,  1'b1, 32'hDEADBEEF};
      vec_a[7]  = '{1'b0, 32'h030, 32'hCAFEF00D, 4'hA, 8'd8,  1'b1, 32'h0};
      vec_a[8]  = '{1'b1, 32'h030, 32'h0,        4'h0, 8'd9,  1'b1, 32'hCA00F000};
      vec_a[9]  = '{1'b1, 32'h3FC, 32'h0,        4'h0, 8'd10, 1'b1, 32'h0};
      vec_a[10] = '{1'b0, 32'h3FC, 32'h12345678, 4'h1, 8'd11, 1'b1, 32'h0};
      vec_a[11] = '{1'b1, 32'h3FC, 32'h0,        4'h0, 8'd12, 1'b1, 32'h00000078};

      vec_b[0] = '{1'b0, 32'h008, 32'h0000ABCD, 4'hF, 8'd1, 1'b0, 32'h0};
      vec_b[1] = '{1'b1, 32'h008, 32'h0,        4'h0, 8'd2, 1'b1, 32'h0000ABCD};
      vec_b[2] = '{1'b0, 32'h00C, 32'h00000077, 4'hF, 8'd3, 1'b0, 32'h0};
      vec_b[3] = '{1'b1, 32'h00C, 32'h0,        4'h0, 8'd4, 1'b1, 32'h00000077};
      vec_b[4] = '{1'b1, 32'h008, 32'h0,        4'h0, 8'd5, 1'b1, 32'h0000ABCD};

      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      drive_b(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      tcdm_a.user = '0; tcdm_a.ecc = '0; tcdm_a.ereq = 1'b0; tcdm_a.r_ready = 1'b1;
      tcdm_b.user = '0; tcdm_b.ecc = '0; tcdm_b.ereq = 1'b0; tcdm_b.r_ready = 1'b1;
      clear_a = 1'b0;
      clear_b = 1'b0;
      rst_n   = 1'b0;

      // Outputs during and right after reset
      #1;
      chk("rst_gnt",     32'(tcdm_a.gnt),     32'd1);
      chk("rst_rvalid",  32'(tcdm_a.r_valid), 32'd0);
      chk("rst_rdata",   tcdm_a.r_data,       32'd0);
      chk("rst_rid",     32'(tcdm_a.r_id),    32'd0);
      chk("rst_egnt",    32'(tcdm_a.egnt),    32'd1);
      chk("rst_revalid", 32'(tcdm_a.r_evalid),32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rvalid", 32'(tcdm_a.r_valid), 32'd0);
      chk("post_rst_gnt",    32'(tcdm_a.gnt),     32'd1);

      // Streaming table: one handshake per cycle, response visible one edge later
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_gnt_pre", i), 32'(tcdm_a.gnt), 32'd1);
         drive_a(1'b1, vec_a[i].wen, vec_a[i].add, vec_a[i].data, vec_a[i].be, vec_a[i].id);
         @(posedge clk); #1;
         chk($sformatf("v%0d_rvalid", i), 32'(tcdm_a.r_valid), 32'(vec_a[i].exp_valid));
         chk($sformatf("v%0d_rdata", i),  tcdm_a.r_data,       vec_a[i].exp_data);
         chk($sformatf("v%0d_rid", i),    32'(tcdm_a.r_id),    32'(vec_a[i].id));
         chk($sformatf("v%0d_gnt", i),    32'(tcdm_a.gnt),     32'd1);
      end
      @(negedge clk);
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      @(posedge clk); #1;
      chk("stream_drain_rvalid", 32'(tcdm_a.r_valid), 32'd0);

      // Backpressure: two reads fill the FIFO, third request is not granted
      @(negedge clk);
      tcdm_a.r_ready = 1'b0;
      drive_a(1'b1, 1'b1, 32'h010, 32'h0, 4'h0, 8'd20);
      @(posedge clk); #1;
      chk("bp_lat_rvalid", 32'(tcdm_a.r_valid), 32'd1);
      chk("bp_lat_rdata",  tcdm_a.r_data,       32'hDEADBEEF);
      chk("bp_gnt1",       32'(tcdm_a.gnt),     32'd1);
      @(negedge clk);
      drive_a(1'b1, 1'b1, 32'h020, 32'h0, 4'h0, 8'd21);
      @(posedge clk); #1;
      chk("bp_full_gnt", 32'(tcdm_a.gnt),  32'd0);
      chk("bp_head_id",  32'(tcdm_a.r_id), 32'd20);
      @(negedge clk);
      drive_a(1'b1, 1'b1, 32'h030, 32'h0, 4'h0, 8'd22);
      @(posedge clk); #1;
      chk("bp_stall_gnt", 32'(tcdm_a.gnt),  32'd0);
      chk("bp_stall_id",  32'(tcdm_a.r_id), 32'd20);
      @(negedge clk);
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      tcdm_a.r_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_second_rvalid", 32'(tcdm_a.r_valid), 32'd1);
      chk("bp_second_id",     32'(tcdm_a.r_id),    32'd21);
      chk("bp_second_data",   tcdm_a.r_data,       32'h11BB33DD);
      chk("bp_second_gnt",    32'(tcdm_a.gnt),     32'd1);
      @(posedge clk); #1;
      chk("bp_empty_rvalid", 32'(tcdm_a.r_valid), 32'd0);

      // Clear with two pending responses, then clear alongside a write handshake
      @(negedge clk);
      tcdm_a.r_ready = 1'b0;
      drive_a(1'b1, 1'b0, 32'h040, 32'h55667788, 4'hF, 8'd30);
      @(posedge clk);
      @(negedge clk);
      drive_a(1'b1, 1'b1, 32'h040, 32'h0, 4'h0, 8'd31);
      @(posedge clk); #1;
      chk("clr_pre_gnt",    32'(tcdm_a.gnt),  32'd0);
      chk("clr_pre_wr_rsp", 32'(tcdm_a.r_id), 32'd30);
      @(negedge clk);
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      clear_a = 1'b1;
      @(posedge clk); #1;
      chk("clr_rvalid", 32'(tcdm_a.r_valid), 32'd0);
      chk("clr_gnt",    32'(tcdm_a.gnt),     32'd1);
      @(negedge clk);
      drive_a(1'b1, 1'b0, 32'h050, 32'h0BADF00D, 4'hF, 8'd40);
      @(posedge clk); #1;
      chk("clr_hs_rvalid", 32'(tcdm_a.r_valid), 32'd0);
      @(negedge clk);
      clear_a = 1'b0;
      tcdm_a.r_ready = 1'b1;
      drive_a(1'b1, 1'b1, 32'h040, 32'h0, 4'h0, 8'd41);
      @(posedge clk); #1;
      chk("clr_mem40_data", tcdm_a.r_data,    32'h55667788);
      chk("clr_mem40_id",   32'(tcdm_a.r_id), 32'd41);
      @(negedge clk);
      drive_a(1'b1, 1'b1, 32'h050, 32'h0, 4'h0, 8'd42);
      @(posedge clk); #1;
      chk("clr_mem50_data", tcdm_a.r_data, 32'h0BADF00D);
      @(negedge clk);
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      @(posedge clk);

      // Reset mid-stream drops the pending response and zeroes memory
      @(negedge clk);
      tcdm_a.r_ready = 1'b0;
      drive_a(1'b1, 1'b1, 32'h010, 32'h0, 4'h0, 8'd50);
      @(posedge clk); #1;
      chk("mrst_pending", 32'(tcdm_a.r_valid), 32'd1);
      @(negedge clk);
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      rst_n = 1'b0;
      #1;
      chk("mrst_rvalid", 32'(tcdm_a.r_valid), 32'd0);
      chk("mrst_gnt",    32'(tcdm_a.gnt),     32'd1);
      chk("mrst_rid",    32'(tcdm_a.r_id),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mrst_after_rvalid", 32'(tcdm_a.r_valid), 32'd0);
      @(negedge clk);
      tcdm_a.r_ready = 1'b1;
      drive_a(1'b1, 1'b1, 32'h010, 32'h0, 4'h0, 8'd51);
      @(posedge clk); #1;
      chk("mrst_read_valid", 32'(tcdm_a.r_valid), 32'd1);
      chk("mrst_read_data",  tcdm_a.r_data,       32'h0);
      chk("mrst_read_id",    32'(tcdm_a.r_id),    32'd51);
      @(negedge clk);
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);

      // No-write-response variant: only reads produce r_valid
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_b(1'b1, vec_b[i].wen, vec_b[i].add, vec_b[i].data, vec_b[i].be, vec_b[i].id);
         @(posedge clk); #1;
         chk($sformatf("b%0d_rvalid", i), 32'(tcdm_b.r_valid), 32'(vec_b[i].exp_valid));
         chk($sformatf("b%0d_gnt", i),    32'(tcdm_b.gnt),     32'd1);
         if (vec_b[i].exp_valid) begin
            chk($sformatf("b%0d_rdata", i), tcdm_b.r_data,    vec_b[i].exp_data);
            chk($sformatf("b%0d_rid", i),   32'(tcdm_b.r_id), 32'(vec_b[i].id));
         end
      end
      @(negedge clk);
      drive_b(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
      @(posedge clk); #1;
      chk("b_drain_rvalid", 32'(tcdm_b.r_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
